// File: rtl/avsd_sar_adc_ctrl_if.sv
// Signal bundle between a SAR ADC controller (slave) and the analog front end / host (master).
// Optional macro SAR_CONT_EN adds the CONT continuous-mode request.
interface avsd_sar_adc_ctrl_if;
    logic       start;
    logic       COMP;
`ifdef SAR_CONT_EN
    logic       CONT;
`endif
    logic [9:0] D;
    logic       SAMPLE;
    logic       BUSY;
    logic [9:0] DATA;
    logic       VALID;

    modport master (
`ifdef SAR_CONT_EN
        output CONT,
`endif
        output start,
        output COMP,
        input  D,
        input  SAMPLE,
        input  BUSY,
        input  DATA,
        input  VALID
    );

    modport slave (
`ifdef SAR_CONT_EN
        input  CONT,
`endif
        input  start,
        input  COMP,
        output D,
        output SAMPLE,
        output BUSY,
        output DATA,
        output VALID
    );
endinterface

// File: rtl/avsd_sar_adc_ctrl.sv
// 10-bit successive-approximation ADC controller: IDLE -> TRACK -> CONVERT (10 bits) -> DONE.
// Optional macro SAR_CONT_EN: DONE with CONT=1 restarts tracking directly without an IDLE cycle.
module avsd_sar_adc_ctrl #(
    parameter int unsigned SAMPLE_CYCLES = 2
) (
    input logic                CLK,
    input logic                reset,
    avsd_sar_adc_ctrl_if.slave bus
);

    typedef enum logic [1:0] {StIdle, StTrack, StConvert, StDone} state_e;

    localparam logic [3:0] TrackLast = 4'(SAMPLE_CYCLES - 1);

    state_e     state_q, state_d;
    logic [9:0] d_q, d_d;
    logic [9:0] data_q, data_d;
    logic       sample_q, sample_d;
    logic       busy_q, busy_d;
    logic       valid_q, valid_d;
    logic [3:0] bit_q, bit_d;
    logic [3:0] cnt_q, cnt_d;
    logic [9:0] mask;
    logic [9:0] trial;

    always_comb begin
        state_d  = state_q;
        d_d      = d_q;
        data_d   = data_q;
        sample_d = sample_q;
        busy_d   = busy_q;
        valid_d  = 1'b0;
        bit_d    = bit_q;
        cnt_d    = cnt_q;
        mask     = 10'd1 << bit_q;
        // Resolve the bit under trial from the comparator decision.
        trial    = bus.COMP ? d_q : (d_q & ~mask);

        unique case (state_q)
            StIdle: begin
                d_d      = 10'd0;
                sample_d = 1'b0;
                busy_d   = 1'b0;
                if (bus.start) begin
                    state_d  = StTrack;
                    sample_d = 1'b1;
                    busy_d   = 1'b1;
                    cnt_d    = 4'd0;
                end
            end
            StTrack: begin
                if (cnt_q == TrackLast) begin
                    state_d  = StConvert;
                    sample_d = 1'b0;
                    d_d      = 10'h200;
                    bit_d    = 4'd9;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            StConvert: begin
                if (bit_q == 4'd0) begin
                    state_d = StDone;
                    d_d     = trial;
                    data_d  = trial;
                    valid_d = 1'b1;
                end else begin
                    d_d   = trial | (mask >> 1);
                    bit_d = bit_q - 4'd1;
                end
            end
            StDone: begin
                bit_d = 4'd9;
`ifdef SAR_CONT_EN
                if (bus.CONT) begin
                    state_d  = StTrack;
                    d_d      = 10'd0;
                    sample_d = 1'b1;
                    busy_d   = 1'b1;
                    cnt_d    = 4'd0;
                end else begin
                    state_d  = StIdle;
                    d_d      = 10'd0;
                    sample_d = 1'b0;
                    busy_d   = 1'b0;
                end
`else
                state_d  = StIdle;
                d_d      = 10'd0;
                sample_d = 1'b0;
                busy_d   = 1'b0;
`endif
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            state_q  <= StIdle;
            d_q      <= 10'd0;
            data_q   <= 10'd0;
            sample_q <= 1'b0;
            busy_q   <= 1'b0;
            valid_q  <= 1'b0;
            bit_q    <= 4'd9;
            cnt_q    <= 4'd0;
        end else begin
            state_q  <= state_d;
            d_q      <= d_d;
            data_q   <= data_d;
            sample_q <= sample_d;
            busy_q   <= busy_d;
            valid_q  <= valid_d;
            bit_q    <= bit_d;
            cnt_q    <= cnt_d;
        end
    end

    assign bus.D      = d_q;
    assign bus.SAMPLE = sample_q;
    assign bus.BUSY   = busy_q;
    assign bus.DATA   = data_q;
    assign bus.VALID  = valid_q;

endmodule

// File: tb/tb_avsd_sar_adc_ctrl.sv
// Self-checking bench for avsd_sar_adc_ctrl with an ideal comparator model COMP = (VIN >= D).
// Covers the SAR_CONT_EN continuous mode when that macro is defined.
module tb_avsd_sar_adc_ctrl;

    logic       CLK = 1'b0;
    logic       reset;
    logic [9:0] vin;

    always #5 CLK = ~CLK;

    avsd_sar_adc_ctrl_if bus ();
    avsd_sar_adc_ctrl_if bus1 ();
    avsd_sar_adc_ctrl_if bus15 ();

    assign bus.COMP   = (vin >= bus.D);
    assign bus1.COMP  = (vin >= bus1.D);
    assign bus15.COMP = (vin >= bus15.D);

    avsd_sar_adc_ctrl #(.SAMPLE_CYCLES(2))  dut   (.CLK(CLK), .reset(reset), .bus(bus));
    avsd_sar_adc_ctrl #(.SAMPLE_CYCLES(1))  dut1  (.CLK(CLK), .reset(reset), .bus(bus1));
    avsd_sar_adc_ctrl #(.SAMPLE_CYCLES(15)) dut15 (.CLK(CLK), .reset(reset), .bus(bus15));

    int         tests = 0;
    int         fails = 0;
    logic [9:0] sb[$];
    logic [9:0] exp_v;
    int         lat, ns, nv, nd;
    logic [9:0] dout;
    logic [9:0] trace[4];

    // Start one conversion on the default instance and observe it until it returns to IDLE.
    task automatic do_conv(input logic [9:0] v, input bit extra);
        int n;
        bit got;
        vin = v;
        sb.push_back(v);
        bus.start = 1'b1;
        @(posedge CLK); #1;
        bus.start = 1'b0;
        n = 0; got = 0; lat = -1; ns = 0; nv = 0; nd = 0; dout = 'x;
        while (n < 40) begin
            if (bus.SAMPLE) ns++;
            if (bus.D != 10'd0 && nd < 4) begin
                trace[nd] = bus.D;
                nd++;
            end
            if (bus.VALID) begin
                nv++;
                if (!got) begin
                    lat  = n;
                    dout = bus.DATA;
                    got  = 1;
                end
            end
            bus.start = extra && (n < 10) && (n % 2 == 1);
            if (got && n >= lat + 2) break;
            @(posedge CLK); #1;
            n++;
        end
        bus.start = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.start = 0; bus1.start = 0; bus15.start = 0;
`ifdef SAR_CONT_EN
        bus.CONT = 0; bus1.CONT = 0; bus15.CONT = 0;
`endif
        vin = 10'd0;
        #3;
        tests++;
        if ({bus.D, bus.SAMPLE, bus.BUSY, bus.DATA, bus.VALID} !== 23'd0) begin
            fails++;
            $display("FAIL reset_outputs: got D=%h S=%b B=%b DATA=%h V=%b, want all zero",
                     bus.D, bus.SAMPLE, bus.BUSY, bus.DATA, bus.VALID);
        end
        tests++;
        if ({bus1.BUSY, bus15.BUSY, bus1.DATA, bus15.DATA} !== 22'd0) begin
            fails++;
            $display("FAIL reset_param_insts: got BUSY=%b%b DATA=%h/%h, want zero",
                     bus1.BUSY, bus15.BUSY, bus1.DATA, bus15.DATA);
        end
        @(posedge CLK); #1;
        reset = 1'b0;
    endtask

    task automatic test_single();
        do_conv(10'h2AB, 0);
        exp_v = sb.pop_front();
        tests++;
        if (lat !== 12) begin
            fails++; $display("FAIL single_latency: got %0d, want 12", lat);
        end
        tests++;
        if (dout !== exp_v) begin
            fails++; $display("FAIL single_data: got %h, want %h", dout, exp_v);
        end
        tests++;
        if (nv !== 1) begin
            fails++; $display("FAIL single_valid_count: got %0d, want 1", nv);
        end
        tests++;
        if ({trace[0], trace[1], trace[2], trace[3]} !== {10'h200, 10'h300, 10'h280, 10'h2C0}) begin
            fails++;
            $display("FAIL d_sequence: got %h %h %h %h, want 200 300 280 2c0",
                     trace[0], trace[1], trace[2], trace[3]);
        end
    endtask

    task automatic test_stuck();
        do_conv(10'h000, 0);
        exp_v = sb.pop_front();
        tests++;
        if (dout !== exp_v) begin
            fails++; $display("FAIL stuck0_data: got %h, want %h", dout, exp_v);
        end
        tests++;
        if (ns !== 2) begin
            fails++; $display("FAIL stuck0_sample_cycles: got %0d, want 2", ns);
        end
        do_conv(10'h3FF, 0);
        exp_v = sb.pop_front();
        tests++;
        if (dout !== exp_v) begin
            fails++; $display("FAIL stuck1_data: got %h, want %h", dout, exp_v);
        end
        tests++;
        if (ns !== 2) begin
            fails++; $display("FAIL stuck1_sample_cycles: got %0d, want 2", ns);
        end
    endtask

    task automatic test_ignore_start();
        do_conv(10'h155, 1);
        exp_v = sb.pop_front();
        tests++;
        if (nv !== 1 || lat !== 12) begin
            fails++; $display("FAIL ignore_start: got valid=%0d lat=%0d, want 1 and 12", nv, lat);
        end
        tests++;
        if (dout !== exp_v) begin
            fails++; $display("FAIL ignore_start_data: got %h, want %h", dout, exp_v);
        end
        repeat (5) @(posedge CLK);
        #1;
        tests++;
        if (bus.DATA !== exp_v || bus.BUSY !== 1'b0) begin
            fails++;
            $display("FAIL data_hold: got DATA=%h BUSY=%b, want %h and 0", bus.DATA, bus.BUSY, exp_v);
        end
    endtask

    task automatic test_back_to_back();
        int t, v, gap, t1, t2;
        vin = 10'h3FF;
        sb.push_back(10'h3FF);
        sb.push_back(10'h3FF);
        bus.start = 1'b1;
        t = 0; v = 0; gap = 0; t1 = -1; t2 = -1;
        while (t < 60 && v < 2) begin
            @(posedge CLK); #1;
            t++;
            if (bus.VALID) begin
                v++;
                if (v == 1) t1 = t;
                else begin
                    t2 = t;
                    bus.start = 1'b0;
                end
                exp_v = (sb.size() > 0) ? sb.pop_front() : 10'bx;
                tests++;
                if (bus.DATA !== exp_v) begin
                    fails++; $display("FAIL b2b_data: got %h, want %h", bus.DATA, exp_v);
                end
            end
            if (v == 1 && !bus.BUSY) gap++;
        end
        bus.start = 1'b0;
        tests++;
        if (t1 !== 13 || t2 - t1 !== 14) begin
            fails++; $display("FAIL b2b_timing: got first=%0d spacing=%0d, want 13 and 14", t1, t2 - t1);
        end
        tests++;
        if (gap !== 1) begin
            fails++; $display("FAIL b2b_idle_gap: got %0d, want 1", gap);
        end
        repeat (3) @(posedge CLK);
        #1;
    endtask

    task automatic test_reset_mid();
        vin = 10'h2AB;
        sb.push_back(10'h2AB);
        bus.start = 1'b1;
        @(posedge CLK); #1;
        bus.start = 1'b0;
        repeat (6) @(posedge CLK);
        #3;
        reset = 1'b1;
        #1;
        void'(sb.pop_front());
        tests++;
        if ({bus.D, bus.SAMPLE, bus.BUSY, bus.DATA, bus.VALID} !== 23'd0) begin
            fails++;
            $display("FAIL reset_mid_async: got D=%h S=%b B=%b DATA=%h V=%b, want all zero",
                     bus.D, bus.SAMPLE, bus.BUSY, bus.DATA, bus.VALID);
        end
        @(posedge CLK); #1;
        tests++;
        if ({bus.VALID, bus.BUSY, bus.DATA} !== 12'd0) begin
            fails++;
            $display("FAIL reset_mid_held: got V=%b B=%b DATA=%h, want zero",
                     bus.VALID, bus.BUSY, bus.DATA);
        end
        reset = 1'b0;
        do_conv(10'h2AB, 0);
        exp_v = sb.pop_front();
        tests++;
        if (dout !== exp_v || lat !== 12 || nv !== 1) begin
            fails++;
            $display("FAIL after_reset_conv: got data=%h lat=%0d valid=%0d, want %h 12 1",
                     dout, lat, nv, exp_v);
        end
    endtask

    task automatic test_sample_cycles();
        int n, l1, l15;
        logic [9:0] d1, d15;
        vin = 10'h0CC;
        sb.push_back(10'h0CC);
        bus1.start = 1'b1;
        bus15.start = 1'b1;
        @(posedge CLK); #1;
        bus1.start = 1'b0;
        bus15.start = 1'b0;
        n = 0; l1 = -1; l15 = -1; d1 = 'x; d15 = 'x;
        while (n < 40 && (l1 < 0 || l15 < 0)) begin
            @(posedge CLK); #1;
            n++;
            if (bus1.VALID && l1 < 0) begin l1 = n; d1 = bus1.DATA; end
            if (bus15.VALID && l15 < 0) begin l15 = n; d15 = bus15.DATA; end
        end
        exp_v = sb.pop_front();
        tests++;
        if (l1 !== 11 || l15 !== 25) begin
            fails++; $display("FAIL sample_cycles_latency: got %0d/%0d, want 11/25", l1, l15);
        end
        tests++;
        if (d1 !== exp_v || d15 !== exp_v) begin
            fails++; $display("FAIL sample_cycles_data: got %h/%h, want %h", d1, d15, exp_v);
        end
        repeat (3) @(posedge CLK);
        #1;
    endtask

`ifdef SAR_CONT_EN
    task automatic test_cont();
        int t, v, last;
        bit busy_ok;
        logic [9:0] steps[3];
        steps[0] = 10'h001; steps[1] = 10'h155; steps[2] = 10'h155;
        vin = steps[0];
        for (int i = 0; i < 3; i++) sb.push_back(steps[i]);
        bus.CONT = 1'b1;
        bus.start = 1'b1;
        @(posedge CLK); #1;
        bus.start = 1'b0;
        t = 0; v = 0; last = 0; busy_ok = 1;
        while (t < 60 && v < 3) begin
            if (!bus.BUSY) busy_ok = 0;
            @(posedge CLK); #1;
            t++;
            if (bus.VALID) begin
                exp_v = sb.pop_front();
                tests++;
                if (bus.DATA !== exp_v) begin
                    fails++; $display("FAIL cont_data: got %h, want %h", bus.DATA, exp_v);
                end
                if (v > 0) begin
                    tests++;
                    if (t - last !== 13) begin
                        fails++; $display("FAIL cont_period: got %0d, want 13", t - last);
                    end
                end
                last = t;
                v++;
                if (v < 3) vin = steps[v];
                else bus.CONT = 1'b0;
            end
        end
        tests++;
        if (!busy_ok || v !== 3) begin
            fails++; $display("FAIL cont_busy: got busy_ok=%b valids=%0d, want 1 and 3", busy_ok, v);
        end
        repeat (3) @(posedge CLK);
        #1;
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single();
        test_stuck();
        test_ignore_start();
        test_back_to_back();
        test_reset_mid();
        test_sample_cycles();
`ifdef SAR_CONT_EN
        test_cont();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
